// File: rtl/md5_hash8_core.sv
// Single-block MD5 engine for fixed 8-byte ASCII candidates.
// One round per clock; start/done handshake with the digest in printed byte order.
module md5_hash8_core (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [63:0]  msg,
  output logic         busy,
  output logic         done,
  output logic [127:0] hash
);

  typedef enum logic [1:0] {IDLE, INIT, ROUND, FINAL} state_t;

  localparam logic [31:0] A0 = 32'h67452301;
  localparam logic [31:0] B0 = 32'hefcdab89;
  localparam logic [31:0] C0 = 32'h98badcfe;
  localparam logic [31:0] D0 = 32'h10325476;

  localparam logic [31:0] K_ROM [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Shift amounts repeat every four rounds within each 16-round group.
  localparam logic [4:0] R_ROM [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  state_t      state, state_nxt;
  logic [63:0] blk;
  logic [31:0] a, b, c, d;
  logic [5:0]  cnt;

  logic [31:0] f, w_sel, k_val, sum, rot, b_nxt;
  logic [3:0]  g, c4;
  logic [4:0]  r_val;
  logic [63:0] rot_dbl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT:    state_nxt = ROUND;
      ROUND:   if (cnt == 6'd63) state_nxt = FINAL;
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == INIT) || (state == ROUND);

  // Round function, message word index and rotate for the current cnt.
  always_comb begin
    c4 = cnt[3:0];
    f  = '0;
    g  = '0;
    case (cnt[5:4])
      2'd0: begin f = (b & c) | (~b & d); g = c4; end
      2'd1: begin f = (d & b) | (~d & c); g = c4 * 4'd5 + 4'd1; end
      2'd2: begin f = b ^ c ^ d;          g = c4 * 4'd3 + 4'd5; end
      default: begin f = c ^ (b | ~d);    g = c4 * 4'd7; end
    endcase

    // Padded block: only words 0, 1 (message), 2 (0x80 marker) and 14 (bit length) are non-zero.
    case (g)
      4'd0:    w_sel = {blk[39:32], blk[47:40], blk[55:48], blk[63:56]};
      4'd1:    w_sel = {blk[7:0], blk[15:8], blk[23:16], blk[31:24]};
      4'd2:    w_sel = 32'h00000080;
      4'd14:   w_sel = 32'h00000040;
      default: w_sel = 32'h00000000;
    endcase

    k_val   = K_ROM[cnt];
    r_val   = R_ROM[{cnt[5:4], cnt[1:0]}];
    sum     = a + f + k_val + w_sel;
    rot_dbl = {sum, sum} << r_val;
    rot     = rot_dbl[63:32];
    b_nxt   = b + rot;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk  <= '0;
      a    <= '0;
      b    <= '0;
      c    <= '0;
      d    <= '0;
      cnt  <= '0;
      done <= 1'b0;
      hash <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) blk <= msg;
        INIT: begin
          a   <= A0;
          b   <= B0;
          c   <= C0;
          d   <= D0;
          cnt <= '0;
        end
        ROUND: begin
          a   <= d;
          d   <= c;
          c   <= b;
          b   <= b_nxt;
          cnt <= cnt + 6'd1;
        end
        FINAL: begin
          hash <= {bswap(A0 + a), bswap(B0 + b), bswap(C0 + c), bswap(D0 + d)};
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_hash8_core.sv
// Directed-vector bench for md5_hash8_core: latency, digests, start filtering and reset behaviour.
module tb_md5_hash8_core;

  localparam logic [63:0]  MSG_A  = 64'h3132333435363738;
  localparam logic [63:0]  MSG_B  = 64'h3030303030303030;
  localparam logic [127:0] HASH_A = 128'h25d55ad283aa400af464c76d713c07ad;
  localparam logic [127:0] HASH_B = 128'hdd4b21e9ef71e1291183a46b913ae6f2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [63:0]  msg = '0;
  logic         busy, done;
  logic [127:0] hash;

  int tests = 0;
  int failed = 0;

  md5_hash8_core dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .msg     (msg),
    .busy    (busy),
    .done    (done),
    .hash    (hash)
  );

  always #5 clk = ~clk;

  // Caller sits at a falling edge; start is high across exactly one rising edge.
  task automatic kick(input logic [63:0] m);
    msg   = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts rising edges until done, sampling at falling edges; optionally pulses a stray start.
  task automatic wait_done(input int inject_at, output int done_edge, output int busy_cnt,
                           output logic busy_at_done, output logic [127:0] mid_hash,
                           output logic [127:0] done_hash);
    done_edge    = -1;
    busy_cnt     = busy ? 1 : 0;
    busy_at_done = 1'bx;
    mid_hash     = hash;
    done_hash    = '0;
    for (int n = 1; n <= 200; n++) begin
      if (n == inject_at) begin msg = MSG_B; start = 1'b1; end
      if (n == inject_at + 1) start = 1'b0;
      @(negedge clk);
      if (n == 30) mid_hash = hash;
      if (done) begin
        done_edge    = n;
        busy_at_done = busy;
        done_hash    = hash;
        break;
      end
      if (busy) busy_cnt++;
    end
    start = 1'b0;
  endtask

  task automatic count_dones(input int cycles, output int ndone);
    ndone = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b1;
    msg     = MSG_A;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin failed++; $display("[TB] FAIL reset_done got %b want 0", done); end
    tests++; if (hash !== '0) begin failed++; $display("[TB] FAIL reset_hash got %h want 0", hash); end
    start   = 1'b0;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin failed++; $display("[TB] FAIL idle_done got %b want 0", done); end
  endtask

  task automatic test_known_vector();
    int de, bc; logic bd; logic [127:0] mh, dh;
    kick(MSG_A);
    msg = MSG_B;
    wait_done(-10, de, bc, bd, mh, dh);
    tests++; if (de !== 66) begin failed++; $display("[TB] FAIL a_latency got %0d want 66", de); end
    tests++; if (dh !== HASH_A) begin failed++; $display("[TB] FAIL a_hash got %h want %h", dh, HASH_A); end
    tests++; if (bc !== 65) begin failed++; $display("[TB] FAIL a_busy_cycles got %0d want 65", bc); end
    tests++; if (bd !== 1'b0) begin failed++; $display("[TB] FAIL a_busy_at_done got %b want 0", bd); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin failed++; $display("[TB] FAIL a_done_pulse got %b want 0", done); end
  endtask

  task automatic test_second_vector();
    int de, bc; logic bd; logic [127:0] mh, dh;
    kick(MSG_B);
    wait_done(-10, de, bc, bd, mh, dh);
    tests++; if (mh !== HASH_A) begin failed++; $display("[TB] FAIL b_hash_held got %h want %h", mh, HASH_A); end
    tests++; if (de !== 66) begin failed++; $display("[TB] FAIL b_latency got %0d want 66", de); end
    tests++; if (dh !== HASH_B) begin failed++; $display("[TB] FAIL b_hash got %h want %h", dh, HASH_B); end
    repeat (3) @(negedge clk);
    tests++; if (hash !== HASH_B) begin failed++; $display("[TB] FAIL b_hash_after got %h want %h", hash, HASH_B); end
  endtask

  task automatic test_ignored_start();
    int de, bc, nd; logic bd; logic [127:0] mh, dh;
    kick(MSG_A);
    wait_done(10, de, bc, bd, mh, dh);
    tests++; if (de !== 66) begin failed++; $display("[TB] FAIL ign_latency got %0d want 66", de); end
    tests++; if (dh !== HASH_A) begin failed++; $display("[TB] FAIL ign_hash got %h want %h", dh, HASH_A); end
    tests++; if (bc !== 65) begin failed++; $display("[TB] FAIL ign_busy_cycles got %0d want 65", bc); end
    count_dones(80, nd);
    tests++; if (nd !== 0) begin failed++; $display("[TB] FAIL ign_extra_done got %0d want 0", nd); end
  endtask

  task automatic test_back_to_back();
    int de1, de2, bc; logic bd; logic [127:0] mh, dh1, dh2;
    kick(MSG_B);
    wait_done(-10, de1, bc, bd, mh, dh1);
    kick(MSG_A);
    wait_done(-10, de2, bc, bd, mh, dh2);
    tests++; if (dh1 !== HASH_B) begin failed++; $display("[TB] FAIL b2b_hash1 got %h want %h", dh1, HASH_B); end
    tests++; if (de2 + 1 !== 67) begin failed++; $display("[TB] FAIL b2b_gap got %0d want 67", de2 + 1); end
    tests++; if (dh2 !== HASH_A) begin failed++; $display("[TB] FAIL b2b_hash2 got %h want %h", dh2, HASH_A); end
  endtask

  task automatic test_async_reset();
    int de, bc, nd; logic bd; logic [127:0] mh, dh;
    kick(MSG_B);
    repeat (31) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL arst_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin failed++; $display("[TB] FAIL arst_done got %b want 0", done); end
    tests++; if (hash !== '0) begin failed++; $display("[TB] FAIL arst_hash got %h want 0", hash); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    count_dones(80, nd);
    tests++; if (nd !== 0) begin failed++; $display("[TB] FAIL arst_stray_done got %0d want 0", nd); end
    kick(MSG_B);
    wait_done(-10, de, bc, bd, mh, dh);
    tests++; if (de !== 66) begin failed++; $display("[TB] FAIL arst_latency got %0d want 66", de); end
    tests++; if (dh !== HASH_B) begin failed++; $display("[TB] FAIL arst_hash_after got %h want %h", dh, HASH_B); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_known_vector();
    test_second_vector();
    test_ignored_start();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
